ldst_owner_scheduler: RTL and testbench



---
 rtl/ldst_owner_scheduler_pkg.sv | 25 ++
 rtl/ldst_owner_scheduler_if.sv | 38 +++
 rtl/ldst_inflight_counter.sv | 42 ++++
 rtl/ldst_owner_scheduler.sv | 114 +++++++++++
 tb/tb_ldst_owner_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ldst_owner_scheduler_pkg.sv
// ldst_pkg
// Shared definitions for the load/store ownership scheduler slice.
//   - ldstStateT plus state constants for the ownership FSM
//   - pipe select encodings (which requester's mux leg is active)
//   - access order encodings used by the load/store requesters
package ldst_pkg;

    typedef logic [1:0] ldstStateT;

    // Stable owners alternate with a drain state; the drain state is
    // where the pipe empties before the select is allowed to flip.
    localparam ldstStateT ST_EXE       = 2'd0;
    localparam ldstStateT ST_TO_EXCEPT = 2'd1;
    localparam ldstStateT ST_EXCEPT    = 2'd2;
    localparam ldstStateT ST_TO_EXE    = 2'd3;

    localparam logic LDST_SEL_EXE    = 1'b0;
    localparam logic LDST_SEL_EXCEPT = 1'b1;

    localparam logic [1:0] ORDER_BYTE = 2'b00;
    localparam logic [1:0] ORDER_HALF = 2'b01;
    localparam logic [1:0] ORDER_WORD = 2'b10;
    localparam logic [1:0] ORDER_NONE = 2'b11;

endpackage

// File: rtl/ldst_owner_scheduler_if.sv
// ldst_owner_scheduler_if
// Bundles every handshake/bus signal of the ownership scheduler.
//   Requester side : iEXE_REQ/oEXE_BUSY/oEXE_VALID,
//                    iEXCEPT_REQ/iEXCEPT_LOCK/oEXCEPT_BUSY/oEXCEPT_VALID
//   Pipe side      : oLDST_REQ/iLDST_BUSY/iLDST_VALID
//   Status         : oUSE_SEL, oINFLIGHT, oERROR
// Modport master is the environment (requesters + pipe), slave is the
// scheduler itself. Signal names keep the scheduler's i/o point of view.
interface ldst_owner_scheduler_if #(
    parameter int P_CNT_W = 4
);
    logic               iEXE_REQ;
    logic               oEXE_BUSY;
    logic               oEXE_VALID;
    logic               iEXCEPT_REQ;
    logic               iEXCEPT_LOCK;
    logic               oEXCEPT_BUSY;
    logic               oEXCEPT_VALID;
    logic               oLDST_REQ;
    logic               iLDST_BUSY;
    logic               iLDST_VALID;
    logic               oUSE_SEL;
    logic [P_CNT_W-1:0] oINFLIGHT;
    logic               oERROR;

    modport master (
        output iEXE_REQ, iEXCEPT_REQ, iEXCEPT_LOCK, iLDST_BUSY, iLDST_VALID,
        input  oEXE_BUSY, oEXE_VALID, oEXCEPT_BUSY, oEXCEPT_VALID,
        input  oLDST_REQ, oUSE_SEL, oINFLIGHT, oERROR
    );

    modport slave (
        input  iEXE_REQ, iEXCEPT_REQ, iEXCEPT_LOCK, iLDST_BUSY, iLDST_VALID,
        output oEXE_BUSY, oEXE_VALID, oEXCEPT_BUSY, oEXCEPT_VALID,
        output oLDST_REQ, oUSE_SEL, oINFLIGHT, oERROR
    );

endinterface

// File: rtl/ldst_inflight_counter.sv
// ldst_inflight_counter
// Up/down counter of accepted-but-unanswered pipe transactions.
//   clock, reset : core clock, synchronous active-high reset
//   inc          : a request was accepted this cycle
//   dec          : a response returned this cycle
//   count        : registered in-flight count
//   full         : count has reached P_MAX_OUTSTANDING
//   empty        : count is zero
//   underflow    : a response arrived with nothing in flight
module ldst_inflight_counter #(
    parameter int P_MAX_OUTSTANDING = 4,
    parameter int P_CNT_W           = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [P_CNT_W-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               underflow
);

    localparam logic [P_CNT_W-1:0] MAX_COUNT = P_CNT_W'(P_MAX_OUTSTANDING);

    assign full      = (count >= MAX_COUNT);
    assign empty     = (count == '0);
    assign underflow = dec && empty;

    // Simultaneous accept and response cancel out. The count saturates at
    // both ends, so a stray response leaves it at zero instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ldst_owner_scheduler.sv
// ldst_owner_scheduler
// Decides whether the Execution or the Exception unit owns the shared
// load/store pipe, gates each side's request/busy handshake, routes
// responses by the registered select and only flips the select once the
// pipe has fully drained.
//   iCLOCK      : core clock
//   iRESET_SYNC : synchronous active-high reset
//   bus         : ldst_owner_scheduler_if.slave carrying all handshakes,
//                 the select (oUSE_SEL), in-flight count and sticky error
module ldst_owner_scheduler
    import ldst_pkg::*;
#(
    parameter int P_MAX_OUTSTANDING = 4,
    parameter int P_CNT_W           = 4
) (
    input  logic                         iCLOCK,
    input  logic                         iRESET_SYNC,
    ldst_owner_scheduler_if.slave        bus
);

    ldstStateT          state;
    logic               useSel;
    logic               error;
    logic               issueOk;
    logic               ldstReq;
    logic               accept;
    logic [P_CNT_W-1:0] count;
    logic               full;
    logic               empty;
    logic               underflow;

    ldst_inflight_counter #(
        .P_MAX_OUTSTANDING (P_MAX_OUTSTANDING),
        .P_CNT_W           (P_CNT_W)
    ) uCounter (
        .clock     (iCLOCK),
        .reset     (iRESET_SYNC),
        .inc       (accept),
        .dec       (bus.iLDST_VALID),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .underflow (underflow)
    );

    // An Exception request blocks Execution issue in the very cycle it
    // appears, so the drain never has to chase a freshly issued request.
    always_comb begin
        issueOk = 1'b0;
        case (state)
            ST_EXE:    issueOk = !bus.iEXCEPT_REQ && !full;
            ST_EXCEPT: issueOk = !full;
            default:   issueOk = 1'b0;
        endcase
    end

    assign ldstReq = issueOk && (useSel ? bus.iEXCEPT_REQ : bus.iEXE_REQ);
    assign accept  = ldstReq && !bus.iLDST_BUSY;

    assign bus.oLDST_REQ     = ldstReq;
    assign bus.oEXE_BUSY     = (useSel == LDST_SEL_EXE)    ? (!issueOk || bus.iLDST_BUSY) : 1'b1;
    assign bus.oEXCEPT_BUSY  = (useSel == LDST_SEL_EXCEPT) ? (!issueOk || bus.iLDST_BUSY) : 1'b1;
    assign bus.oEXE_VALID    = bus.iLDST_VALID && (useSel == LDST_SEL_EXE);
    assign bus.oEXCEPT_VALID = bus.iLDST_VALID && (useSel == LDST_SEL_EXCEPT);
    assign bus.oUSE_SEL      = useSel;
    assign bus.oINFLIGHT     = count;
    assign bus.oERROR        = error;

    // Ownership FSM. The select only changes on leaving a drain state with
    // the registered count at zero, which guarantees every outstanding
    // response returns to the requester that issued it.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state  <= ST_EXE;
            useSel <= LDST_SEL_EXE;
        end else begin
            case (state)
                ST_EXE: begin
                    if (bus.iEXCEPT_REQ) begin
                        state <= ST_TO_EXCEPT;
                    end
                end
                ST_TO_EXCEPT: begin
                    if (empty) begin
                        state  <= ST_EXCEPT;
                        useSel <= LDST_SEL_EXCEPT;
                    end
                end
                ST_EXCEPT: begin
                    if (!bus.iEXCEPT_REQ && !bus.iEXCEPT_LOCK) begin
                        state <= ST_TO_EXE;
                    end
                end
                default: begin
                    if (empty) begin
                        state  <= ST_EXE;
                        useSel <= LDST_SEL_EXE;
                    end
                end
            endcase
        end
    end

    // A response with nothing in flight is a protocol violation; it is
    // remembered until the next reset.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            error <= 1'b0;
        end else if (underflow) begin
            error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ldst_owner_scheduler.sv
// tb_ldst_owner_scheduler
// Directed self-checking bench. A behavioural ownership model (owner flag,
// pending-switch flag, integer in-flight count, sticky error) is compared
// against the DUT on every falling edge; literal checks pin the model.
module tb_ldst_owner_scheduler;

    localparam int MAX_OUT = 4;
    localparam int CNT_W   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;

    bit modelValid = 1'b0;
    bit mSel       = 1'b0;
    bit mDrain     = 1'b0;
    bit mErr       = 1'b0;
    int mCnt       = 0;

    ldst_owner_scheduler_if #(.P_CNT_W(CNT_W)) bus ();

    ldst_owner_scheduler #(
        .P_MAX_OUTSTANDING (MAX_OUT),
        .P_CNT_W           (CNT_W)
    ) dut (
        .iCLOCK      (clock),
        .iRESET_SYNC (reset),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit exeReq, input bit exceptReq, input bit lock,
                                 input bit busy, input bit valid, input bit rst, input int cycles);
        bus.iEXE_REQ     = exeReq;
        bus.iEXCEPT_REQ  = exceptReq;
        bus.iEXCEPT_LOCK = lock;
        bus.iLDST_BUSY   = busy;
        bus.iLDST_VALID  = valid;
        reset            = rst;
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic stepCycles(input int cycles);
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Model: the owner may issue while not switching and below the limit
    // (Execution additionally yields whenever Exception asks); the owner
    // flips once a pending switch sees an empty pipe.
    always @(negedge clock) begin
        bit ok;
        bit expReq;
        bit acc;
        int nextCnt;
        if (mDrain) ok = 1'b0;
        else if (!mSel) ok = !bus.iEXCEPT_REQ && (mCnt < MAX_OUT);
        else ok = (mCnt < MAX_OUT);
        expReq = ok && (mSel ? bus.iEXCEPT_REQ : bus.iEXE_REQ);
        acc    = expReq && !bus.iLDST_BUSY;
        if (modelValid) begin
            checkOutput("ldstReq",     32'(bus.oLDST_REQ),     32'(expReq));
            checkOutput("exeBusy",     32'(bus.oEXE_BUSY),     32'(mSel ? 1'b1 : (!ok || bus.iLDST_BUSY)));
            checkOutput("exceptBusy",  32'(bus.oEXCEPT_BUSY),  32'(mSel ? (!ok || bus.iLDST_BUSY) : 1'b1));
            checkOutput("exeValid",    32'(bus.oEXE_VALID),    32'(bus.iLDST_VALID && !mSel));
            checkOutput("exceptValid", 32'(bus.oEXCEPT_VALID), 32'(bus.iLDST_VALID && mSel));
            checkOutput("useSel",      32'(bus.oUSE_SEL),      32'(mSel));
            checkOutput("inflight",    32'(bus.oINFLIGHT),     32'(mCnt));
            checkOutput("error",       32'(bus.oERROR),        32'(mErr));
        end
        if (reset) begin
            mSel       = 1'b0;
            mDrain     = 1'b0;
            mErr       = 1'b0;
            mCnt       = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (mDrain) begin
                if (mCnt == 0) begin
                    mDrain = 1'b0;
                    mSel   = !mSel;
                end
            end else if (!mSel && bus.iEXCEPT_REQ) begin
                mDrain = 1'b1;
            end else if (mSel && !bus.iEXCEPT_REQ && !bus.iEXCEPT_LOCK) begin
                mDrain = 1'b1;
            end
            if (bus.iLDST_VALID && mCnt == 0) mErr = 1'b1;
            nextCnt = mCnt + int'(acc) - int'(bus.iLDST_VALID);
            mCnt = (nextCnt < 0) ? 0 : nextCnt;
        end
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 1, 1);

        // Reset values, and Execution busy following the pipe busy.
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("pin reset useSel",     32'(bus.oUSE_SEL),     0);
        checkOutput("pin reset inflight",   32'(bus.oINFLIGHT),    0);
        checkOutput("pin reset error",      32'(bus.oERROR),       0);
        checkOutput("pin reset exceptBusy", 32'(bus.oEXCEPT_BUSY), 1);
        checkOutput("pin reset exeBusy",    32'(bus.oEXE_BUSY),    0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        #1;
        checkOutput("pin reset exeBusy follows", 32'(bus.oEXE_BUSY), 1);

        // Fill to the limit.
        applyStimulus(1, 0, 0, 0, 0, 0, 6);
        checkOutput("pin fill inflight", 32'(bus.oINFLIGHT), 4);
        checkOutput("pin fill exeBusy",  32'(bus.oEXE_BUSY), 1);

        // Response at full frees a slot only for the next cycle.
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        #1;
        checkOutput("pin full exeValid", 32'(bus.oEXE_VALID), 1);
        checkOutput("pin full ldstReq",  32'(bus.oLDST_REQ),  0);
        stepCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("pin freed inflight", 32'(bus.oINFLIGHT), 3);
        checkOutput("pin freed exeBusy",  32'(bus.oEXE_BUSY), 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);

        // Switch to Exception with two in flight.
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        #1;
        checkOutput("pin switch ldstReq", 32'(bus.oLDST_REQ), 0);
        stepCycles(1);
        applyStimulus(0, 1, 0, 0, 1, 0, 0);
        #1;
        checkOutput("pin drain exeValid", 32'(bus.oEXE_VALID), 1);
        stepCycles(2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        #1;
        checkOutput("pin drained useSel", 32'(bus.oUSE_SEL), 0);
        stepCycles(1);
        checkOutput("pin owned useSel",   32'(bus.oUSE_SEL),  1);
        checkOutput("pin owned ldstReq",  32'(bus.oLDST_REQ), 1);
        stepCycles(2);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        #1;
        checkOutput("pin except exceptValid", 32'(bus.oEXCEPT_VALID), 1);
        checkOutput("pin except exeValid",    32'(bus.oEXE_VALID),    0);
        stepCycles(2);

        // Lock holds ownership, release returns via one drain cycle.
        applyStimulus(0, 0, 1, 0, 0, 0, 5);
        checkOutput("pin lock useSel", 32'(bus.oUSE_SEL), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("pin toExe useSel", 32'(bus.oUSE_SEL), 1);
        stepCycles(1);
        checkOutput("pin back useSel", 32'(bus.oUSE_SEL), 0);

        // Accept and response together, then a stray response.
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 0, 1);
        checkOutput("pin cancel inflight", 32'(bus.oINFLIGHT), 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        #1;
        checkOutput("pin stray exeValid", 32'(bus.oEXE_VALID), 1);
        checkOutput("pin stray errorPre", 32'(bus.oERROR),     0);
        stepCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 3);
        checkOutput("pin sticky error",    32'(bus.oERROR),    1);
        checkOutput("pin stray inflight",  32'(bus.oINFLIGHT), 0);

        // Reset with three in flight under Exception ownership.
        applyStimulus(0, 1, 0, 0, 0, 0, 2);
        checkOutput("pin fast switch useSel", 32'(bus.oUSE_SEL), 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 3);
        checkOutput("pin except inflight", 32'(bus.oINFLIGHT), 3);
        applyStimulus(0, 1, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("pin midReset useSel",   32'(bus.oUSE_SEL),  0);
        checkOutput("pin midReset inflight", 32'(bus.oINFLIGHT), 0);
        checkOutput("pin midReset error",    32'(bus.oERROR),    0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("pin late stray error", 32'(bus.oERROR), 1);

        // Exception request withdrawn mid-drain still completes the switch.
        applyStimulus(1, 0, 0, 0, 0, 0, 2);
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("pin withdrawn useSel", 32'(bus.oUSE_SEL), 1);
        stepCycles(1);
        checkOutput("pin withdrawn drain useSel", 32'(bus.oUSE_SEL), 1);
        stepCycles(1);
        checkOutput("pin withdrawn back useSel", 32'(bus.oUSE_SEL), 0);

        // Pipe busy blocks acceptance.
        applyStimulus(1, 0, 0, 1, 0, 0, 3);
        checkOutput("pin busy inflight", 32'(bus.oINFLIGHT), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
